pe_logic: RTL and testbench



---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_regfile.sv | 26 ++
 rtl/pe_logic.sv | 148 ++++++++++++++
 tb/tb_pe_logic.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants, FSM state type and MAC helper for the PE datapath
package pe_pkg;

  localparam int DEPTH_F_DEF = 3;
  localparam int DEPTH_I_DEF = 5;
  localparam int WIDTH_F_DEF = 8;
  localparam int WIDTH_I_DEF = 1;
  localparam int PSUM_W_DEF  = 8;
  localparam int WIDTH_DEF   = 39;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    ADD,
    OUT,
    DONE
  } pe_state_t;

  // Operands arrive zero-extended; callers truncate to the psum width.
  function automatic logic [31:0] pe_mul(input logic [31:0] f, input logic [31:0] a);
    return f * a;
  endfunction

endpackage

// File: rtl/pe_regfile.sv
// rtl/pe_regfile.sv - single write port, single async read port register array
module pe_regfile #(
  parameter int DEPTH = 3,
  parameter int W     = 8,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Contents survive reset; writes past the array end are silently dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/pe_logic.sv
// rtl/pe_logic.sv - PE datapath: 1-D valid convolution over filter/ifmap memories with psum chaining
module pe_logic
  import pe_pkg::*;
#(
  parameter int DEPTH_F = DEPTH_F_DEF,
  parameter int DEPTH_I = DEPTH_I_DEF,
  parameter int WIDTH_F = WIDTH_F_DEF,
  parameter int WIDTH_I = WIDTH_I_DEF,
  parameter int PSUM_W  = PSUM_W_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       filter_wr_valid,
  output logic                       filter_wr_ready,
  input  logic [$clog2(DEPTH_F)-1:0] filter_wr_addr,
  input  logic [WIDTH_F-1:0]         filter_wr_data,
  input  logic                       ifmap_wr_valid,
  output logic                       ifmap_wr_ready,
  input  logic [$clog2(DEPTH_I)-1:0] ifmap_wr_addr,
  input  logic [WIDTH_I-1:0]         ifmap_wr_data,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic                       psum_in_valid,
  output logic                       psum_in_ready,
  input  logic [PSUM_W-1:0]          psum_in_data,
  output logic                       psum_out_valid,
  input  logic                       psum_out_ready,
  output logic [PSUM_W-1:0]          psum_out_data,
  output logic                       done_valid,
  input  logic                       done_ready
);

  localparam int FAW = $clog2(DEPTH_F);
  localparam int IAW = $clog2(DEPTH_I);

  if (DEPTH_I < DEPTH_F || WIDTH < 1) begin : g_bad_params
    $error("pe_logic: DEPTH_I must be >= DEPTH_F");
  end

  pe_state_t         state_q, state_d;
  logic [PSUM_W-1:0] acc_q, acc_d;
  logic [PSUM_W-1:0] result_q, result_d;
  logic [IAW-1:0]    j_q, j_d;
  logic [FAW-1:0]    k_q, k_d;
  logic              rdy_q, rdy_d;
  logic              idle_rdy;
  logic [WIDTH_F-1:0] filter_rd;
  logic [WIDTH_I-1:0] ifmap_rd;

  // rdy_q keeps the IDLE readies low until the first edge after reset release.
  assign idle_rdy        = (state_q == IDLE) && rdy_q;
  assign filter_wr_ready = idle_rdy;
  assign ifmap_wr_ready  = idle_rdy;
  assign start_ready     = idle_rdy;
  assign psum_in_ready   = (state_q == ADD);
  assign psum_out_valid  = (state_q == OUT);
  assign psum_out_data   = result_q;
  assign done_valid      = (state_q == DONE);

  pe_regfile #(.DEPTH(DEPTH_F), .W(WIDTH_F), .AW(FAW)) u_filter (
    .clk     (clk),
    .wr_en   (filter_wr_valid && filter_wr_ready),
    .wr_addr (filter_wr_addr),
    .wr_data (filter_wr_data),
    .rd_addr (k_q),
    .rd_data (filter_rd)
  );

  pe_regfile #(.DEPTH(DEPTH_I), .W(WIDTH_I), .AW(IAW)) u_ifmap (
    .clk     (clk),
    .wr_en   (ifmap_wr_valid && ifmap_wr_ready),
    .wr_addr (ifmap_wr_addr),
    .wr_data (ifmap_wr_data),
    .rd_addr (j_q + IAW'(k_q)),
    .rd_data (ifmap_rd)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    j_d      = j_q;
    k_d      = k_q;
    rdy_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          acc_d   = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = PSUM_W'(32'(acc_q) + pe_mul(32'(filter_rd), 32'(ifmap_rd)));
        if (k_q == FAW'(DEPTH_F - 1)) begin
          state_d = ADD;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ADD: begin
        if (psum_in_valid) begin
          result_d = acc_q + psum_in_data;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (psum_out_ready) begin
          if (j_q < IAW'(DEPTH_I - DEPTH_F)) begin
            j_d     = j_q + 1'b1;
            k_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      j_q      <= j_d;
      k_q      <= k_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: tb/tb_pe_logic.sv
// tb/tb_pe_logic.sv - scoreboard bench for pe_logic with directed convolution vectors
module tb_pe_logic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       filter_wr_valid = 1'b0, filter_wr_ready;
  logic [1:0] filter_wr_addr = '0;
  logic [7:0] filter_wr_data = '0;
  logic       ifmap_wr_valid = 1'b0, ifmap_wr_ready;
  logic [2:0] ifmap_wr_addr = '0;
  logic [0:0] ifmap_wr_data = '0;
  logic       start_valid = 1'b0, start_ready;
  logic       psum_in_valid = 1'b0, psum_in_ready;
  logic [7:0] psum_in_data = '0;
  logic       psum_out_valid, psum_out_ready = 1'b1;
  logic [7:0] psum_out_data;
  logic       done_valid, done_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int sb[$];
  int pin_q[$];
  int pin_delay = 0, pin_wait = 0, out_bp = 0, bp_cnt = 0;
  logic hold = 1'b0, in_fire, out_fire;
  int held = 0, exp_v = 0;

  always #5 clk = ~clk;

  pe_logic dut (
    .clk(clk), .rst(rst),
    .filter_wr_valid(filter_wr_valid), .filter_wr_ready(filter_wr_ready),
    .filter_wr_addr(filter_wr_addr), .filter_wr_data(filter_wr_data),
    .ifmap_wr_valid(ifmap_wr_valid), .ifmap_wr_ready(ifmap_wr_ready),
    .ifmap_wr_addr(ifmap_wr_addr), .ifmap_wr_data(ifmap_wr_data),
    .start_valid(start_valid), .start_ready(start_ready),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .psum_out_data(psum_out_data),
    .done_valid(done_valid), .done_ready(done_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every psum/done transfer; -1 marks the done token.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) check("psum_out_stable", psum_out_data, held);
        if (psum_out_valid || done_valid)
          check("busy_readies_low", {filter_wr_ready, ifmap_wr_ready, start_ready}, 0);
        if (psum_out_valid && psum_out_ready) begin
          if (sb.size() == 0) check("psum_out_extra", 1, 0);
          else begin
            exp_v = sb.pop_front();
            check("psum_out", psum_out_data, exp_v);
          end
        end
        if (done_valid && done_ready) begin
          if (sb.size() == 0) check("done_extra", 1, 0);
          else begin
            exp_v = sb.pop_front();
            check("done_order", exp_v, -1);
          end
        end
        hold = psum_out_valid && !psum_out_ready;
        held = psum_out_data;
      end
    end
  end

  // psum_in source: each value is offered pin_delay cycles after the previous one is consumed.
  initial begin
    forever begin
      @(negedge clk);
      in_fire = psum_in_valid && psum_in_ready;
      @(posedge clk); #1;
      if (in_fire && pin_q.size() > 0) begin
        void'(pin_q.pop_front());
        psum_in_valid = 1'b0;
        pin_wait = 0;
      end else if (!psum_in_valid && pin_q.size() > 0) begin
        if (pin_wait >= pin_delay) begin
          psum_in_valid = 1'b1;
          psum_in_data = 8'(pin_q[0]);
        end else pin_wait++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      out_fire = psum_out_valid && psum_out_ready;
      @(posedge clk); #1;
      if (out_bp == 0) psum_out_ready = 1'b1;
      else if (out_fire) begin
        psum_out_ready = 1'b0;
        bp_cnt = 0;
      end else if (psum_out_valid) begin
        if (bp_cnt >= out_bp) psum_out_ready = 1'b1;
        else bp_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic write(input logic fv, input int fa, input int fd, input logic iv, input int ia, input int id);
    int n = 0;
    @(posedge clk); #1;
    filter_wr_valid = fv; filter_wr_addr = 2'(fa); filter_wr_data = 8'(fd);
    ifmap_wr_valid = iv; ifmap_wr_addr = 3'(ia); ifmap_wr_data = 1'(id);
    while (n < 50) begin
      @(negedge clk);
      if ((!fv || filter_wr_ready) && (!iv || ifmap_wr_ready)) break;
      n++;
    end
    check("wr_accept", int'(n < 50), 1);
    @(posedge clk); #1;
    filter_wr_valid = 1'b0;
    ifmap_wr_valid = 1'b0;
  endtask

  task automatic start_run();
    int n = 0;
    @(posedge clk); #1;
    start_valid = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (start_ready) break;
      n++;
    end
    check("start_accept", int'(n < 50), 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run(input int e0, input int e1, input int e2, input int p0, input int p1,
                     input int p2, input int dly, input int bp);
    sb.push_back(e0); sb.push_back(e1); sb.push_back(e2); sb.push_back(-1);
    pin_q.push_back(p0); pin_q.push_back(p1); pin_q.push_back(p2);
    pin_delay = dly; pin_wait = 0;
    out_bp = bp; bp_cnt = 0;
    if (bp > 0) psum_out_ready = 1'b0;
    start_run();
    wait_drain(500);
    out_bp = 0;
  endtask

  task automatic load_func();
    write(1, 0, 14, 1, 0, 1);
    write(1, 1, 5, 1, 1, 1);
    write(1, 2, 8, 1, 2, 1);
    write(0, 0, 0, 1, 3, 0);
    write(0, 0, 0, 1, 4, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psum_out_valid"}, psum_out_valid, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_psum_out_data"}, psum_out_data, 0);
    check({tag, "_psum_in_ready"}, psum_in_ready, 0);
    check({tag, "_readies"}, {filter_wr_ready, ifmap_wr_ready, start_ready}, 0);
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check("ready_before_edge", {filter_wr_ready, ifmap_wr_ready, start_ready}, 0);
    @(posedge clk); #1;
    check("ready_after_edge", {filter_wr_ready, ifmap_wr_ready, start_ready}, 7);

    load_func();
    run(27, 19, 22, 0, 0, 0, 0, 0);
    run(37, 19, 16, 10, 0, 250, 5, 0);
    run(27, 19, 22, 0, 0, 0, 0, 10);

    // Abort during the second MAC pass, right after the first result leaves.
    sb.push_back(27);
    pin_q.push_back(0); pin_q.push_back(0); pin_q.push_back(0);
    pin_delay = 0; pin_wait = 0;
    start_run();
    wait_drain(100);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    pin_q.delete();
    psum_in_valid = 1'b0;
    pin_wait = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrun_ready_after_edge", {filter_wr_ready, ifmap_wr_ready, start_ready}, 7);
    run(27, 19, 22, 0, 0, 0, 0, 0);

    write(1, 3, 99, 0, 0, 0);
    run(27, 19, 22, 0, 0, 0, 0, 0);

    for (int a = 0; a < 5; a++) write(a < 3, a, 255, 1, a, 1);
    run(253, 253, 253, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
